// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioning path: debounce FSM state
// encoding and the default qualification length.
package btn_pkg;

  // Debounce FSM states. Bit 1 doubles as the debounced level; the two
  // *_WAIT states are the ones where a transition is being qualified.
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } btn_state_e;

  // Default number of stable synchronized cycles needed to accept an edge
  // (1 ms at 50 MHz).
  localparam int DEBOUNCE_CYCLES_DEF = 50000;

endpackage : btn_pkg

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input bit.
// RESET_VAL sets the level both flops take during reset, so the output
// comes out of reset at the input's idle level and no false edge is seen.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic sync1;
  logic sync2;

  // Two back-to-back flops; sync1 may go metastable, sync2 is the clean copy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
    end
  end

  assign q = sync2;

endmodule : sync_2ff

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronizes a raw bouncy input, qualifies each
// transition with a stability counter, and emits one-cycle press/release
// pulses plus a debounced level. pulse_out feeds the pulse-sequence
// detector's x_in downstream.
//
// The FSM state is held in the enum-typed variable `state` so checkers can
// bind to it by name.
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 16,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_in,
  output logic pulse_out,
  output logic release_out,
  output logic level_out,
  output logic busy
);

  // Terminal count: the edge that sees cnt at this value while the input is
  // still stable accepts the transition.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q;
  logic             s_btn;
  btn_state_e       state;
  logic [CNT_W-1:0] cnt;

  // Flops reset to the raw inactive level so s_btn reads "released".
  sync_2ff #(
    .RESET_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (btn_in),
    .q    (sync_q)
  );

  // Normalize polarity: s_btn = 1 always means pressed.
  assign s_btn = sync_q ^ ACTIVE_LOW;

  // Debounce FSM with counter; all outputs are registered alongside state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      pulse_out   <= 1'b0;
      release_out <= 1'b0;
      level_out   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Event outputs last a single cycle unless re-asserted below.
      pulse_out   <= 1'b0;
      release_out <= 1'b0;
      case (state)
        IDLE: begin
          if (s_btn) begin
            state     <= PRESS_WAIT;
            cnt       <= '0;
            busy      <= 1'b1;
            level_out <= 1'b0;
          end
        end
        PRESS_WAIT: begin
          if (!s_btn) begin
            // Bounce: abandon qualification silently.
            state     <= IDLE;
            busy      <= 1'b0;
            level_out <= 1'b0;
          end else if (cnt == CNT_MAX) begin
            state     <= PRESSED;
            pulse_out <= 1'b1;
            busy      <= 1'b0;
            level_out <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!s_btn) begin
            state     <= RELEASE_WAIT;
            cnt       <= '0;
            busy      <= 1'b1;
            level_out <= 1'b1;
          end
        end
        RELEASE_WAIT: begin
          if (s_btn) begin
            // Bounce back to pressed: no new press event.
            state     <= PRESSED;
            busy      <= 1'b0;
            level_out <= 1'b1;
          end else if (cnt == CNT_MAX) begin
            state       <= IDLE;
            release_out <= 1'b1;
            busy        <= 1'b0;
            level_out   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          busy      <= 1'b0;
          level_out <= 1'b0;
        end
      endcase
    end
  end

endmodule : btn_debounce_pulse

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with DEBOUNCE_CYCLES=4, CNT_W=3.
// One instance uses active-high input, a second uses ACTIVE_LOW=1.
module tb_btn_debounce_pulse;

  localparam int DC   = 4;
  localparam int CW   = 3;
  localparam int NVEC = 23;

  // Clock / reset
  logic clk;
  logic rstn;
  logic btn;
  logic btn_al;
  logic pulse_h, release_h, level_h, busy_h;
  logic pulse_l, release_l, level_l, busy_l;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (CW),
    .ACTIVE_LOW      (1'b0)
  ) u_dut_h (
    .clk         (clk),
    .rstn        (rstn),
    .btn_in      (btn),
    .pulse_out   (pulse_h),
    .release_out (release_h),
    .level_out   (level_h),
    .busy        (busy_h)
  );

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (CW),
    .ACTIVE_LOW      (1'b1)
  ) u_dut_l (
    .clk         (clk),
    .rstn        (rstn),
    .btn_in      (btn_al),
    .pulse_out   (pulse_l),
    .release_out (release_l),
    .level_out   (level_l),
    .busy        (busy_l)
  );

  // Scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Vector table: btn applied before edge k, outputs sampled #1 after it.
  typedef struct packed {
    logic       btn;
    logic [3:0] exp; // {pulse, release, level, busy}
  } vec_t;

  vec_t vecs [NVEC];

  // Driver: applies a bit pattern (bit i before edge i) to one instance and
  // records where events happened on that instance's outputs.
  task automatic run_seq(input bit al, input logic [31:0] pat, input int len,
                         output int p_cnt, output int p_first,
                         output int r_cnt, output int r_first,
                         output int l_first0, output int l_first1,
                         output int ovl);
    logic p, r, l;
    p_cnt = 0; p_first = -1; r_cnt = 0; r_first = -1;
    l_first0 = -1; l_first1 = -1; ovl = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (al) btn_al = pat[i];
      else    btn    = pat[i];
      @(posedge clk);
      #1;
      p = al ? pulse_l   : pulse_h;
      r = al ? release_l : release_h;
      l = al ? level_l   : level_h;
      if (p) begin p_cnt++; if (p_first < 0) p_first = i; end
      if (r) begin r_cnt++; if (r_first < 0) r_first = i; end
      if (p && r) ovl++;
      if (!l && l_first0 < 0) l_first0 = i;
      if (l && l_first1 < 0) l_first1 = i;
    end
  endtask

  int pc, pf, rc, rf, l0, l1, ov;

  initial begin
    // Clean press then release, then a short glitch, starting from IDLE.
    vecs[0]  = '{1'b1, 4'b0000};
    vecs[1]  = '{1'b1, 4'b0000};
    vecs[2]  = '{1'b1, 4'b0001};
    vecs[3]  = '{1'b1, 4'b0001};
    vecs[4]  = '{1'b1, 4'b0001};
    vecs[5]  = '{1'b1, 4'b0001};
    vecs[6]  = '{1'b1, 4'b1010};
    vecs[7]  = '{1'b1, 4'b0010};
    vecs[8]  = '{1'b1, 4'b0010};
    vecs[9]  = '{1'b0, 4'b0010};
    vecs[10] = '{1'b0, 4'b0010};
    vecs[11] = '{1'b0, 4'b0011};
    vecs[12] = '{1'b0, 4'b0011};
    vecs[13] = '{1'b0, 4'b0011};
    vecs[14] = '{1'b0, 4'b0011};
    vecs[15] = '{1'b0, 4'b0100};
    vecs[16] = '{1'b0, 4'b0000};
    vecs[17] = '{1'b1, 4'b0000};
    vecs[18] = '{1'b1, 4'b0000};
    vecs[19] = '{1'b0, 4'b0001};
    vecs[20] = '{1'b0, 4'b0001};
    vecs[21] = '{1'b0, 4'b0000};
    vecs[22] = '{1'b0, 4'b0000};

    // Reset with the button held pressed: everything stays 0.
    rstn = 1'b0; btn = 1'b1; btn_al = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs_h", {pulse_h, release_h, level_h, busy_h}, 0);
    check("reset_outs_l", {pulse_l, release_l, level_l, busy_l}, 0);

    // Release reset with the button still held: one pulse at E6.
    #1 rstn = 1'b1;
    run_seq(1'b0, 32'hFFFF_FFFF, 12, pc, pf, rc, rf, l0, l1, ov);
    check("rst_held_pulse_cnt", pc, 1);
    check("rst_held_pulse_edge", pf, 6);
    check("rst_held_level_edge", l1, 6);
    check("rst_held_level_end", level_h, 1);

    // Let go: single release at E6.
    run_seq(1'b0, 32'h0, 12, pc, pf, rc, rf, l0, l1, ov);
    check("rel_clean_pulse_cnt", pc, 0);
    check("rel_clean_rel_cnt", rc, 1);
    check("rel_clean_rel_edge", rf, 6);

    // Table: clean press/release and short glitch.
    for (int k = 0; k < NVEC; k++) begin
      @(negedge clk);
      btn = vecs[k].btn;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_pulse_rel_level_busy", k),
            {pulse_h, release_h, level_h, busy_h}, vecs[k].exp);
    end

    // Press bounce: 1,1,1,0 then stable 1; final rise at step 4 -> pulse at 10.
    run_seq(1'b0, 32'h0000_FFF7, 16, pc, pf, rc, rf, l0, l1, ov);
    check("press_bounce_pulse_cnt", pc, 1);
    check("press_bounce_pulse_edge", pf, 10);
    check("press_bounce_rel_cnt", rc, 0);

    // Release bounce: 0,1 then stable 0; final fall at step 2 -> release at 8.
    run_seq(1'b0, 32'h0000_0002, 14, pc, pf, rc, rf, l0, l1, ov);
    check("rel_bounce_pulse_cnt", pc, 0);
    check("rel_bounce_rel_cnt", rc, 1);
    check("rel_bounce_rel_edge", rf, 8);
    check("rel_bounce_level_fall", l0, 8);
    check("rel_bounce_overlap", ov, 0);

    // Active-low instance: pressing drives 0.
    run_seq(1'b1, 32'h0, 10, pc, pf, rc, rf, l0, l1, ov);
    check("al_pulse_cnt", pc, 1);
    check("al_pulse_edge", pf, 6);
    check("al_level_rise", l1, 6);
    run_seq(1'b1, 32'hFFFF_FFFF, 10, pc, pf, rc, rf, l0, l1, ov);
    check("al_rel_cnt", rc, 1);
    check("al_rel_edge", rf, 6);

    // Reset during PRESS_WAIT with cnt=2 (after edge 4).
    run_seq(1'b0, 32'hFFFF_FFFF, 5, pc, pf, rc, rf, l0, l1, ov);
    check("midrst_busy_before", busy_h, 1);
    check("midrst_pulse_before", pc, 0);
    rstn = 1'b0;
    #1;
    check("midrst_outs", {pulse_h, release_h, level_h, busy_h}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_outs_held", {pulse_h, release_h, level_h, busy_h}, 0);
    #1 rstn = 1'b1;
    run_seq(1'b0, 32'hFFFF_FFFF, 10, pc, pf, rc, rf, l0, l1, ov);
    check("midrst_after_pulse_cnt", pc, 1);
    check("midrst_after_pulse_edge", pf, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_btn_debounce_pulse

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
- Conditions a raw, asynchronous, bouncy push-button or switch input into clean synchronous events.
- Sits directly upstream of the 4-state pulse-sequence detector; its pulse_out drives that block's x_in.
- Stages: 2-flop synchronizer, then a counter-based debounce FSM.
- Outputs: one-cycle press pulse, one-cycle release pulse, debounced level.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronized cycles required to accept a transition. Legal range 2 to 2**CNT_W.
- CNT_W, 16: width of the debounce counter.
- ACTIVE_LOW, 0: when 1, btn_in is inverted at the input, so a pressed button reads 0.

Ports:
- clk  input  1  system clock
- rstn  input  1  reset, asynchronous, active-low
- btn_in  input  1  raw button, asynchronous to clk, may bounce
- pulse_out  output  1  high for exactly one cycle per accepted press
- release_out  output  1  high for exactly one cycle per accepted release
- level_out  output  1  debounced button state, 1 = pressed
- busy  output  1  high while a transition is being qualified (PRESS_WAIT or RELEASE_WAIT)

Behaviour:
- Reset: rstn low asynchronously forces:
  - both sync flops to the inactive level;
  - state to IDLE and cnt to 0;
  - pulse_out, release_out, level_out and busy to 0.
- Synchronizer: two flops.
  - s_btn = sync2 ^ ACTIVE_LOW, where s_btn = 1 means pressed.
  - Only s_btn is used downstream of the synchronizer.
- FSM states and transitions:
  - IDLE:
    - s_btn=1 → PRESS_WAIT, cnt<=0.
  - PRESS_WAIT:
    - s_btn=0 → IDLE. This is a bounce; no output.
    - cnt==DEBOUNCE_CYCLES-1 → PRESSED, pulse_out<=1.
    - Otherwise cnt<=cnt+1.
  - PRESSED:
    - s_btn=0 → RELEASE_WAIT, cnt<=0.
  - RELEASE_WAIT:
    - s_btn=1 → PRESSED. No new pulse_out.
    - cnt==DEBOUNCE_CYCLES-1 → IDLE, release_out<=1.
    - Otherwise cnt<=cnt+1.
- Registered outputs:
  - level_out = 1 in PRESSED and RELEASE_WAIT.
  - busy = 1 in PRESS_WAIT and RELEASE_WAIT.
  - Both update on the same edge as the state.
  - pulse_out and release_out clear on the following edge unconditionally.
- Latency, with btn_in stable from before edge E0:
  - s_btn valid after E1.
  - PRESS_WAIT entered at E2.
  - PRESSED entered, pulse_out and level_out high, at E(2+DEBOUNCE_CYCLES).
  - pulse_out low again at E(3+DEBOUNCE_CYCLES).
  - Release latency is identical.
- Counter rules:
  - Never exceeds DEBOUNCE_CYCLES-1.
  - Never wraps.
  - Holds its value in IDLE and PRESSED.
- Boundary conditions:
  - A bounce of any length shorter than DEBOUNCE_CYCLES restarts qualification from cnt=0 on the next transition.
  - pulse_out and release_out are never high in the same cycle.
  - Two consecutive pulse_out events always have a release_out between them.
  - rstn asserted mid-qualification discards the partial count; no pulse is produced.
  - After rstn deasserts with the button held, a press is qualified normally and one pulse_out is produced.

Decomposition:
- Shared package btn_pkg holds:
  - state encoding: IDLE=2'b00, PRESS_WAIT=2'b01, PRESSED=2'b10, RELEASE_WAIT=2'b11;
  - default DEBOUNCE_CYCLES constant.
- One sub-module, sync_2ff:
  - generic 2-flop synchronizer with async active-low reset and a reset-value parameter;
  - reused elsewhere for other asynchronous inputs.
- The FSM and counter stay in btn_debounce_pulse.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3 unless noted):
- Reset check: rstn=0 with btn_in=1 → all outputs 0. Release rstn with btn_in held 1 → pulse_out high exactly 1 cycle after E6 (edges counted from release); level_out=1 thereafter.
- Clean press: btn_in 0→1 before E0, held 20 cycles → pulse_out=1 only between E6 and E7; level_out=1 from E6; busy=1 from E2 to E6.
- Press bounce: btn_in 1 for 3 cycles, 0 for 1, 1 for 2, then stable 1 → exactly one pulse_out, 6 edges after the final 0→1; no pulse_out during the bounce.
- Short glitch: btn_in=1 for 2 cycles then 0 → pulse_out, release_out and level_out stay 0; busy pulses, then returns to 0.
- Release with bounce: from PRESSED, btn_in 1→0, back to 1 for 1 cycle, then stable 0 → no extra pulse_out; single release_out 6 edges after the final 1→0; level_out falls on the same edge.
- Polarity and reset mid-operation: ACTIVE_LOW=1, btn_in 1→0 → pulse_out at E6. Separately, rstn asserted while in PRESS_WAIT (cnt=2) → state IDLE, busy=0, no pulse.
